// File: rtl/riscv_io_pkg.sv
// Shared address map, store-size/region enums and byte helpers for the
// core's store-side I/O path.
package riscv_io_pkg;

  localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
  localparam logic [15:0] PERIPH_HI   = 16'h1000;

  localparam logic [1:0] IDX_LEDR   = 2'd0;
  localparam logic [1:0] IDX_LEDG   = 2'd1;
  localparam logic [1:0] IDX_HEX_LO = 2'd2;
  localparam logic [1:0] IDX_HEX_HI = 2'd3;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } st_size_t;

  typedef enum logic [1:0] {
    RG_DMEM     = 2'b00,
    RG_PERIPH   = 2'b01,
    RG_UNMAPPED = 2'b10
  } region_t;

  // Register index bits [11:2] are don't-care, so every 4 KiB page aliases one register.
  function automatic logic is_periph(input logic [31:0] addr);
    return (addr[31:16] == PERIPH_HI) && (addr[15:14] == 2'b00);
  endfunction

  function automatic logic [1:0] periph_idx(input logic [31:0] addr);
    return addr[13:12];
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Replicates store data across byte lanes and builds the byte-enable mask;
// flags half/word stores that do not sit on their natural boundary.
module store_lane_align
  import riscv_io_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic [3:0]  o_mask,
  output logic        o_misaligned
);

  // Lane replication and mask shift; the illegal size leaves the mask empty.
  always_comb begin
    o_data       = i_data;
    o_mask       = 4'b0000;
    o_misaligned = 1'b0;
    case (st_size_t'(i_size))
      SZ_B: begin
        o_data = {4{i_data[7:0]}};
        o_mask = 4'b0001 << i_addr_lo;
      end
      SZ_H: begin
        o_data       = {2{i_data[15:0]}};
        o_mask       = 4'b0011 << i_addr_lo;
        o_misaligned = i_addr_lo[0];
      end
      SZ_W: begin
        o_data       = i_data;
        o_mask       = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        o_data       = i_data;
        o_mask       = 4'b0000;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_demux_3.sv
// Routes the core's single store to data memory, the peripheral register
// bank or the error sink, and exposes peripheral read-back for writeback.
module store_demux_3
  import riscv_io_pkg::*;
#(
  parameter int DMEM_AW   = 11,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 st_en_i,
  input  logic [31:0]          st_addr_i,
  input  logic [31:0]          st_data_i,
  input  logic [1:0]           st_size_i,
  input  logic [31:0]          ld_addr_i,
  output logic [31:0]          ld_data_o,
  output logic                 dmem_we_o,
  output logic [DMEM_AW-1:0]   dmem_addr_o,
  output logic [31:0]          dmem_wdata_o,
  output logic [3:0]           dmem_bmask_o,
  output logic [31:0]          ledr_o,
  output logic [31:0]          ledg_o,
  output logic [31:0]          hex_lo_o,
  output logic [31:0]          hex_hi_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]          w_wdata;
  logic [3:0]           w_bmask;
  logic                 w_misaligned;
  region_t              w_region;
  logic                 w_reject;
  logic                 w_accept;
  logic                 w_periph_we;
  logic [31:0]          r_periph [0:3];
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  store_lane_align u_align (
    .i_size       (st_size_i),
    .i_addr_lo    (st_addr_i[1:0]),
    .i_data       (st_data_i),
    .o_data       (w_wdata),
    .o_mask       (w_bmask),
    .o_misaligned (w_misaligned)
  );

  // Region decode of the store address.
  always_comb begin
    if (st_addr_i[31:DMEM_AW] == {(32-DMEM_AW){1'b0}}) begin
      w_region = RG_DMEM;
    end else if (is_periph(st_addr_i)) begin
      w_region = RG_PERIPH;
    end else begin
      w_region = RG_UNMAPPED;
    end
  end

  assign w_reject    = st_en_i & (w_misaligned | (st_size_t'(st_size_i) == SZ_ILL) |
                                  (w_region == RG_UNMAPPED));
  assign w_accept    = st_en_i & ~w_reject;
  assign w_periph_we = w_accept & (w_region == RG_PERIPH);

  assign dmem_we_o    = ~rst_i & w_accept & (w_region == RG_DMEM);
  assign dmem_addr_o  = st_addr_i[DMEM_AW-1:0];
  assign dmem_wdata_o = w_wdata;
  assign dmem_bmask_o = w_bmask;

  // Peripheral bank: masked byte update; reset wins over a same-cycle store.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_periph[i] <= 32'h0;
      end
    end else if (w_periph_we) begin
      r_periph[periph_idx(st_addr_i)] <=
        merge_bytes(r_periph[periph_idx(st_addr_i)], w_wdata, w_bmask);
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_periph[i] <= r_periph[i];
      end
    end
  end

  // Sticky error flag and saturating reject counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= {ERR_CNT_W{1'b0}};
    end else if (w_reject) begin
      r_err <= 1'b1;
      if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end else begin
      r_err     <= r_err;
      r_err_cnt <= r_err_cnt;
    end
  end

  // Read-back returns the pre-edge register value; no store bypass.
  always_comb begin
    if (is_periph(ld_addr_i)) begin
      ld_data_o = r_periph[periph_idx(ld_addr_i)];
    end else begin
      ld_data_o = 32'h0;
    end
  end

  assign ledr_o    = r_periph[IDX_LEDR];
  assign ledg_o    = r_periph[IDX_LEDG];
  assign hex_lo_o  = r_periph[IDX_HEX_LO];
  assign hex_hi_o  = r_periph[IDX_HEX_HI];
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_store_demux_3.sv
// Directed plus randomized bench for store_demux_3 against an address-range
// reference model of the store distributor.
module tb_store_demux_3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        st_en_i = 1'b0;
  logic [31:0] st_addr_i = 32'h0;
  logic [31:0] st_data_i = 32'h0;
  logic [1:0]  st_size_i = 2'b00;
  logic [31:0] ld_addr_i = 32'h0;
  logic [31:0] ld_data_o;
  logic        dmem_we_o;
  logic [10:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_bmask_o;
  logic [31:0] ledr_o, ledg_o, hex_lo_o, hex_hi_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_reg [0:3];
  logic        mdl_err;
  int          mdl_cnt;

  store_demux_3 #(.DMEM_AW(11), .ERR_CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .st_en_i(st_en_i), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_size_i(st_size_i), .ld_addr_i(ld_addr_i),
    .ld_data_o(ld_data_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_bmask_o(dmem_bmask_o), .ledr_o(ledr_o),
    .ledg_o(ledg_o), .hex_lo_o(hex_lo_o), .hex_hi_o(hex_hi_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_periph(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a < 32'h1000_4000);
  endfunction

  // One cycle: drive, check zero-latency outputs, clock, check registered state.
  task automatic step(input logic rst, input logic en, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] size,
                      input logic [31:0] ld);
    int unsigned a;
    int unsigned idx;
    bit is_d, is_p, bad, reject;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic [31:0] exp_ld;
    a    = addr % 4;
    is_d = addr < 32'd2048;
    is_p = in_periph(addr);
    case (size)
      2'd0: begin bad = 1'b0; exp_data = {24'h0, data[7:0]} * 32'h0101_0101;
                  exp_mask = 4'((1 << a) & 15); end
      2'd1: begin bad = (a % 2) != 0; exp_data = {16'h0, data[15:0]} * 32'h0001_0001;
                  exp_mask = 4'((3 << a) & 15); end
      2'd2: begin bad = a != 0; exp_data = data; exp_mask = 4'hF; end
      default: begin bad = 1'b1; exp_data = 32'h0; exp_mask = 4'h0; end
    endcase
    reject = en && (bad || !(is_d || is_p));
    exp_ld = in_periph(ld) ? mdl_reg[(ld - 32'h1000_0000) / 4096] : 32'h0;

    rst_i = rst; st_en_i = en; st_addr_i = addr; st_data_i = data;
    st_size_i = size; ld_addr_i = ld;
    #1;
    chk("dmem_we", {31'h0, dmem_we_o}, {31'h0, (!rst && en && !reject && is_d)});
    chk("dmem_addr", {21'h0, dmem_addr_o}, addr % 2048);
    if (size != 2'd3) begin
      chk("dmem_wdata", dmem_wdata_o, exp_data);
      chk("dmem_bmask", {28'h0, dmem_bmask_o}, {28'h0, exp_mask});
    end
    chk("ld_data", ld_data_o, exp_ld);

    @(posedge clk_i);
    if (rst) begin
      for (int i = 0; i < 4; i++) mdl_reg[i] = 32'h0;
      mdl_err = 1'b0;
      mdl_cnt = 0;
    end else if (reject) begin
      mdl_err = 1'b1;
      mdl_cnt = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
    end else if (en && is_p) begin
      idx = (addr - 32'h1000_0000) / 4096;
      for (int i = 0; i < 4; i++)
        if (exp_mask[i]) mdl_reg[idx][8*i +: 8] = exp_data[8*i +: 8];
    end
    #1;
    chk("ledr", ledr_o, mdl_reg[0]);
    chk("ledg", ledg_o, mdl_reg[1]);
    chk("hex_lo", hex_lo_o, mdl_reg[2]);
    chk("hex_hi", hex_hi_o, mdl_reg[3]);
    chk("err", {31'h0, err_o}, {31'h0, mdl_err});
    chk("err_cnt", {24'h0, err_cnt_o}, mdl_cnt);
  endtask

  initial begin
    logic [31:0] ra, rd, rl;
    logic [1:0]  rs;
    logic        re;
    int          pick;

    for (int i = 0; i < 4; i++) mdl_reg[i] = 32'h0;
    mdl_err = 1'b0;
    mdl_cnt = 0;

    // Reset
    step(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, 32'h1000_0000);
    chk("reset_ledr", ledr_o, 32'h0);
    chk("reset_cnt", {24'h0, err_cnt_o}, 32'h0);

    // SW to LEDR
    step(1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'd2, 32'h0);
    chk("sw_ledr", ledr_o, 32'hDEAD_BEEF);

    // SB into DMEM lane 3
    step(1'b0, 1'b1, 32'h0000_0013, 32'h0000_00A5, 2'd0, 32'h0);

    // SH into upper half of HEX_LO
    step(1'b0, 1'b1, 32'h1000_2000, 32'hFFFF_FFFF, 2'd2, 32'h0);
    step(1'b0, 1'b1, 32'h1000_2002, 32'h0000_1234, 2'd1, 32'h0);
    chk("sh_hex_lo", hex_lo_o, 32'h1234_FFFF);

    // Misaligned then unmapped
    step(1'b0, 1'b1, 32'h0000_0002, 32'h1111_1111, 2'd2, 32'h0);
    step(1'b0, 1'b1, 32'h2000_0000, 32'h2222_2222, 2'd2, 32'h0);
    chk("err_after_two", {31'h0, err_o}, 32'h1);
    chk("cnt_after_two", {24'h0, err_cnt_o}, 32'd2);

    // Same-cycle load/store to LEDG: old value first, new value next cycle
    step(1'b0, 1'b1, 32'h1000_1000, 32'h0000_0055, 2'd2, 32'h1000_1000);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h1000_1000);
    chk("ld_ledg_new", ld_data_o, 32'h0000_0055);

    // Randomized mix incl. region boundaries
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: ra = $urandom_range(0, 2047);
        1: ra = 32'h1000_0000 + $urandom_range(0, 32'h3FFF);
        2: ra = $urandom;
        default: begin
          case ($urandom_range(0, 5))
            0: ra = 32'h0000_07FC;
            1: ra = 32'h0000_0800;
            2: ra = 32'h0FFF_FFFC;
            3: ra = 32'h1000_4000;
            4: ra = 32'h1000_3FFC;
            default: ra = 32'h1001_0000;
          endcase
          ra = ra + $urandom_range(0, 3);
        end
      endcase
      rd = $urandom;
      rs = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 7) != 0);
      rl = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000_0000 + $urandom_range(0, 32'h3FFF);
      step(1'b0, re, ra, rd, rs, rl);
    end

    // Drive the counter into saturation
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1, 32'h2000_0000, 32'h0, 2'd2, 32'h0);
    chk("cnt_saturated", {24'h0, err_cnt_o}, 32'd255);

    // Reset beats a same-cycle store
    step(1'b0, 1'b1, 32'h1000_3000, 32'hCAFE_0001, 2'd2, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 2'd2, 32'h0);
    step(1'b1, 1'b1, 32'h1000_3000, 32'h0000_0001, 2'd2, 32'h1000_3000);
    chk("rst_hex_hi", hex_hi_o, 32'h0);
    chk("rst_cnt", {24'h0, err_cnt_o}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h1000_3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
